nibble_link_responder: RTL and testbench
========================================

Name: nibble_link_responder

Overview:
- Far end of the 4-bit nibble link driven by the Snitch core wrapper; sits in the eFPGA fabric.
- Receives serialized memory requests, each an 8-bit word address plus either a read command or a 32-bit write sent as 8 nibbles with per-nibble strobes.
- Reassembles each request and issues it on a single-port SRAM-style memory interface.
- Read data returns to the core as 8 nibbles, MSB first, followed by a commit beat.

Parameters:
- AddrWidth, 32, width of mem_addr_o in bits; must be ≥ 10.
- CommitCycles, 1, number of cycles rsp_valid_o stays high after the last nibble is accepted (commit beat); range 1..3.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; reset is synchronous and active-high.
- req_nibble_i  in  4  request write-data nibble.
- req_addr_i  in  8  request word address.
- req_write_i  in  1  1 = write, 0 = read.
- req_strb_i  in  1  strobe for the current write nibble.
- req_valid_i  in  1  request beat valid.
- req_ready_o  out  1  request beat accepted.
- rsp_nibble_o  out  4  response data nibble.
- rsp_last_o  out  1  marks the 8th data nibble.
- rsp_valid_o  out  1  response beat / commit valid.
- rsp_ready_i  in  1  response nibble accepted; the core drives it combinationally from rsp_valid_o.
- mem_req_o  out  1  memory request.
- mem_gnt_i  in  1  memory grant.
- mem_addr_o  out  AddrWidth  byte address = {zeros, addr_q, 2'b00}.
- mem_we_o  out  1  write enable.
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  32  write data.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  32  read data.

Behaviour:
- Reset: state IDLE, all registers 0, and every output 0 except req_ready_o.
  - req_ready_o = 1 in IDLE, including during and directly after reset.
  - Reset mid-operation abandons the transaction with no memory request and no response.
- FSM states: IDLE, WR_COLLECT, MEM_REQ, MEM_WAIT, RSP_SEND, RSP_COMMIT.
- IDLE: req_ready_o = 1. On req_valid_i:
  - Latch addr_q = req_addr_i and we_q = req_write_i.
  - Read (req_write_i = 0): single beat, no data. Go to MEM_REQ.
  - Write: store nibble 0 into wdata[3:0] and strb[0]; set cnt = 1; go to WR_COLLECT.
- WR_COLLECT: req_ready_o = 1.
  - Each valid beat stores into wdata[4*cnt+3:4*cnt] and strb[cnt], then increments cnt.
  - The beat with cnt = 7 goes to MEM_REQ.
  - req_addr_i and req_write_i are ignored after the first beat.
  - Nibbles arrive LSB first.
- Byte enables: mem_be_o[k] = strb[2k] | strb[2k+1].
- MEM_REQ: req_ready_o = 0. mem_req_o = 1 and mem_addr/we/be/wdata stay stable until mem_gnt_i.
  - On grant of a write: go to IDLE. Writes produce no link response.
  - On grant of a read: go to MEM_WAIT.
  - For reads mem_be_o = 4'hF and mem_wdata_o = 0.
- MEM_WAIT: mem_rvalid_i is sampled only in cycles after the grant; read latency ≥ 1.
  - On rvalid, latch rdata into the shift register, set cnt = 0, go to RSP_SEND.
  - Never times out.
- RSP_SEND:
  - rsp_valid_o = 1, rsp_nibble_o = shift[31:28], rsp_last_o = (cnt == 7).
  - On rsp_ready_i: shift left 4 and increment cnt.
  - Acceptance of the last nibble goes to RSP_COMMIT.
  - Without rsp_ready_i, all outputs hold.
- RSP_COMMIT:
  - rsp_valid_o = 1, rsp_last_o = 0, rsp_nibble_o = 0, for exactly CommitCycles cycles.
  - rsp_ready_i is ignored, since the core acks the commit beat silently.
  - Then go to IDLE.
- Only one transaction is outstanding: req_ready_o = 0 in MEM_REQ, MEM_WAIT, RSP_SEND and RSP_COMMIT.
- Latency:
  - Read with grant in the first MEM_REQ cycle and 1-cycle memory: first rsp nibble 3 cycles after the request beat.
  - Write with immediate grant: mem_req_o asserts the cycle after the 8th nibble.
- The first write beat may arrive in the same cycle IDLE is re-entered from any state.
- req_valid_i low between write beats stalls WR_COLLECT indefinitely.

Test Plan:
- Read @ addr 0x12, memory returns 0xDEADBEEF after 1 cycle:
  - mem_addr_o = 0x48, mem_we_o = 0.
  - rsp nibbles D,E,A,D,B,E,E,F with rsp_last_o only on F.
  - Then 1 commit cycle, then IDLE with req_ready_o = 1.
- Write 0xCAFEF00D @ 0x3F, all strobes 1, nibbles sent D,0,0,F,E,F,A,C:
  - Single mem_req_o with mem_addr_o = 0xFC, mem_wdata_o = 0xCAFEF00D, mem_be_o = 4'hF.
  - No rsp_valid_o.
- Write with strobes 1,1,0,0,0,0,1,1 and mem_gnt_i held low 5 cycles:
  - mem_be_o = 4'b1001, stable for all 5 stalled cycles.
  - req_ready_o = 0 throughout the stall.
- Read response with rsp_ready_i low for 3 cycles on nibble 4:
  - Nibble and rsp_last_o hold during the stall.
  - Sequence resumes intact; the full 32-bit word is reconstructed.
- Write with req_valid_i gaps of 2 cycles between beats:
  - Correct assembly of wdata and strobes.
  - req_addr_i changed mid-burst has no effect on mem_addr_o.
- rst_i asserted for 1 cycle during RSP_SEND nibble 3 and separately during WR_COLLECT beat 5:
  - Next cycle all outputs are 0 except req_ready_o = 1.
  - No mem_req_o from the partial write.
  - A following read completes correctly.

Source files
------------

// File: rtl/nibble_link_responder.sv
// Far end of the 4-bit nibble link: reassembles serialized memory requests,
// issues them on a single-port SRAM interface and streams read data back.
module nibble_link_responder #(
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned CommitCycles = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [3:0]           req_nibble_i,
    input  logic [7:0]           req_addr_i,
    input  logic                 req_write_i,
    input  logic                 req_strb_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    output logic [3:0]           rsp_nibble_o,
    output logic                 rsp_last_o,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic                 mem_we_o,
    output logic [3:0]           mem_be_o,
    output logic [31:0]          mem_wdata_o,
    input  logic                 mem_rvalid_i,
    input  logic [31:0]          mem_rdata_i
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WR_COLLECT = 3'd1,
        MEM_REQ    = 3'd2,
        MEM_WAIT   = 3'd3,
        RSP_SEND   = 3'd4,
        RSP_COMMIT = 3'd5
    } state_e;

    localparam logic [1:0] CommitLast = 2'(CommitCycles - 1);

    // A byte is enabled when either of its two nibble strobes was set.
    function automatic logic [3:0] strb_to_be(input logic [7:0] strb);
        logic [3:0] be;
        for (int k = 0; k < 4; k++) begin
            be[k] = strb[2*k] | strb[2*k+1];
        end
        return be;
    endfunction

    state_e      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  strb_q, strb_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;
    logic [1:0]  commit_q, commit_d;

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            addr_q   <= 8'h00;
            we_q     <= 1'b0;
            wdata_q  <= 32'h0000_0000;
            strb_q   <= 8'h00;
            cnt_q    <= 3'd0;
            shift_q  <= 32'h0000_0000;
            commit_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            commit_q <= commit_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        commit_d = commit_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d = req_addr_i;
                    we_d   = req_write_i;
                    if (req_write_i) begin
                        wdata_d = {28'h000_0000, req_nibble_i};
                        strb_d  = {7'h00, req_strb_i};
                        cnt_d   = 3'd1;
                        state_d = WR_COLLECT;
                    end else begin
                        state_d = MEM_REQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WR_COLLECT: begin
                if (req_valid_i) begin
                    wdata_d[{cnt_q, 2'b00} +: 4] = req_nibble_i;
                    strb_d[cnt_q]                = req_strb_i;
                    cnt_d                        = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = MEM_REQ;
                    end else begin
                        state_d = WR_COLLECT;
                    end
                end else begin
                    state_d = WR_COLLECT;
                end
            end
            MEM_REQ: begin
                if (mem_gnt_i) begin
                    state_d = we_q ? IDLE : MEM_WAIT;
                end else begin
                    state_d = MEM_REQ;
                end
            end
            MEM_WAIT: begin
                if (mem_rvalid_i) begin
                    shift_d = mem_rdata_i;
                    cnt_d   = 3'd0;
                    state_d = RSP_SEND;
                end else begin
                    state_d = MEM_WAIT;
                end
            end
            RSP_SEND: begin
                if (rsp_ready_i) begin
                    shift_d = {shift_q[27:0], 4'h0};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        commit_d = 2'd0;
                        state_d  = RSP_COMMIT;
                    end else begin
                        state_d = RSP_SEND;
                    end
                end else begin
                    state_d = RSP_SEND;
                end
            end
            RSP_COMMIT: begin
                // The core acknowledges the commit beat silently, so rsp_ready_i is not consulted.
                if (commit_q == CommitLast) begin
                    state_d = IDLE;
                end else begin
                    commit_d = commit_q + 2'd1;
                    state_d  = RSP_COMMIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode; outputs depend only on registered state.
    always_comb begin
        req_ready_o  = 1'b0;
        rsp_valid_o  = 1'b0;
        rsp_nibble_o = 4'h0;
        rsp_last_o   = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_be_o     = 4'h0;
        mem_wdata_o  = 32'h0000_0000;
        mem_addr_o   = {AddrWidth{1'b0}};
        mem_addr_o[9:0] = {addr_q, 2'b00};
        case (state_q)
            IDLE, WR_COLLECT: begin
                req_ready_o = 1'b1;
            end
            MEM_REQ: begin
                mem_req_o = 1'b1;
                mem_we_o  = we_q;
                if (we_q) begin
                    mem_be_o    = strb_to_be(strb_q);
                    mem_wdata_o = wdata_q;
                end else begin
                    mem_be_o    = 4'hF;
                    mem_wdata_o = 32'h0000_0000;
                end
            end
            RSP_SEND: begin
                rsp_valid_o  = 1'b1;
                rsp_nibble_o = shift_q[31:28];
                rsp_last_o   = (cnt_q == 3'd7);
            end
            RSP_COMMIT: begin
                rsp_valid_o = 1'b1;
            end
            default: begin
                req_ready_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_nibble_link_responder.sv
// Self-checking bench for nibble_link_responder: directed scenarios plus a
// randomized request stream checked against a word-level memory model.
module tb_nibble_link_responder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  req_nibble_i;
    logic [7:0]  req_addr_i;
    logic        req_write_i;
    logic        req_strb_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  rsp_nibble_o;
    logic        rsp_last_o;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mem_req_cycles = 0;
    int rsp_valid_cycles = 0;

    logic [31:0] ref_mem [256];
    logic [31:0] mem_arr [256];

    nibble_link_responder #(.AddrWidth(32), .CommitCycles(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_nibble_i(req_nibble_i), .req_addr_i(req_addr_i), .req_write_i(req_write_i),
        .req_strb_i(req_strb_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .rsp_nibble_o(rsp_nibble_o), .rsp_last_o(rsp_last_o), .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Cycle and activity counters observed at every rising edge.
    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (mem_req_o === 1'b1) mem_req_cycles <= mem_req_cycles + 1;
        if (rsp_valid_o === 1'b1) rsp_valid_cycles <= rsp_valid_cycles + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk_i);
    endtask

    // Everything that must be zero while idle, packed for one comparison.
    function automatic logic [75:0] busy_outputs();
        return {rsp_nibble_o, rsp_last_o, rsp_valid_o, mem_req_o, mem_addr_o,
                mem_we_o, mem_be_o, mem_wdata_o};
    endfunction

    function automatic logic [3:0] model_be(input logic [7:0] strb);
        logic [3:0] be;
        for (int k = 0; k < 4; k++) be[k] = ((strb >> (2*k)) & 8'd3) != 8'd0;
        return be;
    endfunction

    task automatic send_read(input logic [7:0] addr);
        req_valid_i  = 1'b1;
        req_write_i  = 1'b0;
        req_addr_i   = addr;
        req_nibble_i = 4'($urandom);
        req_strb_i   = 1'($urandom);
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic send_write(input logic [7:0] addr, input logic [31:0] data,
                              input logic [7:0] strb, input int gap);
        for (int i = 0; i < 8; i++) begin
            req_valid_i  = 1'b1;
            req_write_i  = (i == 0) ? 1'b1 : 1'($urandom);
            req_addr_i   = (i == 0) ? addr : 8'($urandom);
            req_nibble_i = data[4*i +: 4];
            req_strb_i   = strb[i];
            tick();
            req_valid_i = 1'b0;
            if (i < 7) begin
                for (int g = 0; g < gap; g++) begin
                    req_addr_i = 8'($urandom);
                    tick();
                end
            end
        end
    endtask

    task automatic serve_mem(input int gnt_delay, input int lat, input logic [31:0] rdata,
                             output logic [31:0] a, output logic we, output logic [3:0] be,
                             output logic [31:0] wd, output int wait_cycles,
                             output bit stable, output bit ready_low, output bit timeout);
        wait_cycles = 0; stable = 1'b1; ready_low = 1'b1; timeout = 1'b0;
        a = 32'h0; we = 1'b0; be = 4'h0; wd = 32'h0;
        while (mem_req_o !== 1'b1 && wait_cycles < 100) begin
            tick();
            wait_cycles++;
        end
        if (mem_req_o !== 1'b1) begin
            timeout = 1'b1;
            return;
        end
        a = mem_addr_o; we = mem_we_o; be = mem_be_o; wd = mem_wdata_o;
        for (int i = 0; i < gnt_delay; i++) begin
            if (req_ready_o !== 1'b0) ready_low = 1'b0;
            tick();
            if (mem_req_o !== 1'b1 || mem_addr_o !== a || mem_we_o !== we ||
                mem_be_o !== be || mem_wdata_o !== wd) stable = 1'b0;
        end
        if (req_ready_o !== 1'b0) ready_low = 1'b0;
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        if (!we) begin
            for (int i = 1; i < lat; i++) tick();
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = rdata;
            tick();
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 32'($urandom);
        end
    endtask

    task automatic collect_rsp(input int stall_at, input int stall_len, input int abort_at,
                               output logic [31:0] word, output bit last_ok, output bit hold_ok,
                               output int commit_len, output int first_cyc, output bit timeout);
        int w;
        logic [3:0] nib;
        logic lst;
        word = 32'h0; last_ok = 1'b1; hold_ok = 1'b1; commit_len = 0; timeout = 1'b0; w = 0;
        while (rsp_valid_o !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        first_cyc = cyc;
        if (rsp_valid_o !== 1'b1) begin
            timeout = 1'b1;
            return;
        end
        for (int i = 0; i < 8; i++) begin
            if (i == abort_at) return;
            if (rsp_valid_o !== 1'b1) timeout = 1'b1;
            if (rsp_last_o !== (i == 7)) last_ok = 1'b0;
            if (i == stall_at) begin
                nib = rsp_nibble_o;
                lst = rsp_last_o;
                rsp_ready_i = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    if (rsp_nibble_o !== nib || rsp_last_o !== lst || rsp_valid_o !== 1'b1)
                        hold_ok = 1'b0;
                end
            end
            word = {word[27:0], rsp_nibble_o};
            rsp_ready_i = 1'b1;
            tick();
            rsp_ready_i = 1'b0;
        end
        while (rsp_valid_o === 1'b1 && commit_len < 10) begin
            if (rsp_nibble_o !== 4'h0 || rsp_last_o !== 1'b0) last_ok = 1'b0;
            rsp_ready_i = 1'($urandom);
            commit_len++;
            tick();
        end
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick(); tick();
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_during: got %b expected 1", req_ready_o); end
        checks++; if (busy_outputs() !== 76'h0) begin errors++; $display("FAIL reset_outputs_during: got %h expected 0", busy_outputs()); end
        rst_i = 1'b0;
        tick();
        checks++; if (req_ready_o !== 1'b1 || busy_outputs() !== 76'h0) begin errors++; $display("FAIL reset_after: ready %b outs %h expected 1 and 0", req_ready_o, busy_outputs()); end
    endtask

    task automatic test_read();
        logic [31:0] a, wd, word; logic we; logic [3:0] be;
        int wc, cl, fc, c0; bit st, rl, to, to2, lok, hok;
        c0 = cyc;
        send_read(8'h12);
        serve_mem(0, 1, 32'hDEADBEEF, a, we, be, wd, wc, st, rl, to);
        checks++; if (to || wc != 0 || a !== 32'h48) begin errors++; $display("FAIL read_addr: got %h (wait %0d) expected 00000048", a, wc); end
        checks++; if (we !== 1'b0 || !st || !rl) begin errors++; $display("FAIL read_we: got %b expected 0", we); end
        checks++; if ({be, wd} !== {4'hF, 32'h0}) begin errors++; $display("FAIL read_be_wdata: got %h/%h expected f/00000000", be, wd); end
        collect_rsp(-1, 0, -1, word, lok, hok, cl, fc, to2);
        checks++; if (to2 || fc - c0 != 3) begin errors++; $display("FAIL read_latency: got %0d expected 3", fc - c0); end
        checks++; if (word !== 32'hDEADBEEF || !hok) begin errors++; $display("FAIL read_data: got %h expected deadbeef", word); end
        checks++; if (!lok) begin errors++; $display("FAIL read_last: got misplaced rsp_last_o expected only on nibble 8"); end
        checks++; if (cl != 1) begin errors++; $display("FAIL read_commit: got %0d expected 1", cl); end
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL read_idle_ready: got %b expected 1", req_ready_o); end
    endtask

    task automatic test_write();
        logic [31:0] a, wd; logic we; logic [3:0] be;
        int wc, m0, r0; bit st, rl, to;
        m0 = mem_req_cycles; r0 = rsp_valid_cycles;
        send_write(8'h3F, 32'hCAFEF00D, 8'hFF, 0);
        serve_mem(0, 1, 32'h0, a, we, be, wd, wc, st, rl, to);
        checks++; if (to || wc != 0) begin errors++; $display("FAIL write_latency: got wait %0d expected 0", wc); end
        checks++; if (a !== 32'hFC || we !== 1'b1 || !st || !rl) begin errors++; $display("FAIL write_addr: got %h we %b expected 000000fc we 1", a, we); end
        checks++; if (wd !== 32'hCAFEF00D || be !== 4'hF) begin errors++; $display("FAIL write_data: got %h be %h expected cafef00d be f", wd, be); end
        tick(); tick();
        checks++; if (mem_req_cycles - m0 != 1) begin errors++; $display("FAIL write_single_req: got %0d expected 1", mem_req_cycles - m0); end
        checks++; if (rsp_valid_cycles != r0) begin errors++; $display("FAIL write_no_rsp: got %0d expected 0", rsp_valid_cycles - r0); end
    endtask

    task automatic test_gnt_stall();
        logic [31:0] a, wd, data; logic we; logic [3:0] be;
        int wc; bit st, rl, to;
        data = $urandom;
        send_write(8'h07, data, 8'b1100_0011, 0);
        serve_mem(5, 1, 32'h0, a, we, be, wd, wc, st, rl, to);
        checks++; if (to || be !== 4'b1001 || wd !== data || a !== 32'h1C || we !== 1'b1) begin errors++; $display("FAIL stall_be: got be %b data %h expected 1001 %h", be, wd, data); end
        checks++; if (!st) begin errors++; $display("FAIL stall_stable: got changing request expected stable for 5 cycles"); end
        checks++; if (!rl || wc != 0) begin errors++; $display("FAIL stall_ready: got req_ready_o high expected 0"); end
    endtask

    task automatic test_rsp_stall();
        logic [31:0] a, wd, word, rd; logic we; logic [3:0] be;
        int wc, cl, fc; bit st, rl, to, to2, lok, hok;
        rd = $urandom;
        send_read(8'h33);
        serve_mem(0, 1, rd, a, we, be, wd, wc, st, rl, to);
        collect_rsp(4, 3, -1, word, lok, hok, cl, fc, to2);
        checks++; if (!hok || to2 || fc < 0) begin errors++; $display("FAIL rsp_stall_hold: got changing nibble expected hold"); end
        checks++; if (word !== rd || to || a !== 32'hCC || we !== 1'b0 || {be, wd} !== {4'hF, 32'h0} || wc != 0 || !st || !rl) begin errors++; $display("FAIL rsp_stall_word: got %h expected %h", word, rd); end
        checks++; if (!lok || cl != 1) begin errors++; $display("FAIL rsp_stall_last: commit %0d expected 1 with single last", cl); end
    endtask

    task automatic test_gaps();
        logic [31:0] a, wd, data; logic we; logic [3:0] be; logic [7:0] strb;
        int wc; bit st, rl, to;
        data = $urandom; strb = 8'($urandom);
        send_write(8'h55, data, strb, 2);
        serve_mem(1, 1, 32'h0, a, we, be, wd, wc, st, rl, to);
        checks++; if (to || a !== 32'h154 || we !== 1'b1 || !st || !rl || wc != 0) begin errors++; $display("FAIL gaps_addr: got %h expected 00000154", a); end
        checks++; if (wd !== data) begin errors++; $display("FAIL gaps_wdata: got %h expected %h", wd, data); end
        checks++; if (be !== model_be(strb)) begin errors++; $display("FAIL gaps_be: got %b expected %b", be, model_be(strb)); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, wd, word, rd; logic we; logic [3:0] be;
        int wc, cl, fc, m0, r0; bit st, rl, to, to2, lok, hok;
        send_read(8'h21);
        serve_mem(0, 1, 32'h1234_5678, a, we, be, wd, wc, st, rl, to);
        collect_rsp(-1, 0, 3, word, lok, hok, cl, fc, to2);
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        checks++; if (req_ready_o !== 1'b1 || busy_outputs() !== 76'h0) begin errors++; $display("FAIL rst_rsp_outputs: ready %b outs %h expected 1 and 0", req_ready_o, busy_outputs()); end
        m0 = mem_req_cycles; r0 = rsp_valid_cycles;
        repeat (5) tick();
        checks++; if (mem_req_cycles != m0 || rsp_valid_cycles != r0) begin errors++; $display("FAIL rst_rsp_quiet: got %0d req %0d rsp expected 0", mem_req_cycles - m0, rsp_valid_cycles - r0); end
        for (int i = 0; i < 6; i++) begin
            req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 8'h44;
            req_nibble_i = 4'($urandom); req_strb_i = 1'b1;
            if (i == 5) rst_i = 1'b1;
            tick();
        end
        rst_i = 1'b0; req_valid_i = 1'b0;
        checks++; if (req_ready_o !== 1'b1 || busy_outputs() !== 76'h0) begin errors++; $display("FAIL rst_wr_outputs: ready %b outs %h expected 1 and 0", req_ready_o, busy_outputs()); end
        m0 = mem_req_cycles;
        repeat (10) tick();
        checks++; if (mem_req_cycles != m0) begin errors++; $display("FAIL rst_wr_no_req: got %0d expected 0", mem_req_cycles - m0); end
        rd = $urandom;
        send_read(8'h5A);
        serve_mem(0, 2, rd, a, we, be, wd, wc, st, rl, to);
        collect_rsp(-1, 0, -1, word, lok, hok, cl, fc, to2);
        checks++; if (to || to2 || a !== 32'h168 || word !== rd || !lok || !hok || cl != 1 || we !== 1'b0 || be !== 4'hF || wd !== 32'h0 || !st || !rl || wc != 0 || fc < 0) begin errors++; $display("FAIL rst_followup_read: got %h expected %h", word, rd); end
    endtask

    task automatic test_random();
        logic [31:0] a, wd, word, data; logic we; logic [3:0] be, ebe; logic [7:0] addr, strb;
        int wc, cl, fc; bit st, rl, to, to2, lok, hok;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = $urandom;
            mem_arr[i] = ref_mem[i];
        end
        for (int t = 0; t < 40; t++) begin
            addr = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom; strb = 8'($urandom);
                send_write(addr, data, strb, $urandom_range(0, 2));
                serve_mem($urandom_range(0, 3), 1, 32'h0, a, we, be, wd, wc, st, rl, to);
                ebe = model_be(strb);
                checks++; if (to || a !== 32'(addr) * 32'd4 || we !== 1'b1 || be !== ebe || wd !== data || !st || !rl || wc != 0) begin errors++; $display("FAIL rand_write %0d: got a=%h be=%b wd=%h expected a=%h be=%b wd=%h", t, a, be, wd, 32'(addr) * 32'd4, ebe, data); end
                for (int k = 0; k < 4; k++) begin
                    if (ebe[k]) ref_mem[addr][8*k +: 8] = data[8*k +: 8];
                    if (be[k]) mem_arr[a[9:2]][8*k +: 8] = wd[8*k +: 8];
                end
            end else begin
                send_read(addr);
                serve_mem($urandom_range(0, 3), $urandom_range(1, 3), mem_arr[addr], a, we, be, wd, wc, st, rl, to);
                collect_rsp($urandom_range(0, 7), $urandom_range(0, 2), -1, word, lok, hok, cl, fc, to2);
                checks++; if (to || to2 || a !== 32'(addr) * 32'd4 || we !== 1'b0 || word !== ref_mem[addr] || !lok || !hok || cl != 1 || be !== 4'hF || wd !== 32'h0 || !st || !rl || wc != 0 || fc < 0) begin errors++; $display("FAIL rand_read %0d: got a=%h word=%h expected a=%h word=%h", t, a, word, 32'(addr) * 32'd4, ref_mem[addr]); end
            end
        end
    endtask

    initial begin
        rst_i = 1'b1; req_nibble_i = 4'h0; req_addr_i = 8'h00; req_write_i = 1'b0;
        req_strb_i = 1'b0; req_valid_i = 1'b0; rsp_ready_i = 1'b0; mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        tick();
        test_reset();
        test_read();
        test_write();
        test_gnt_stall();
        test_rsp_stall();
        test_gaps();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
